imuldiv_seq: RTL and testbench

IMULDIV_SEQ -- requirements
Module: imuldiv_seq

---
 rtl/imuldiv_seq_pkg.sv | 29 ++
 rtl/imuldiv_dp.sv | 104 ++++++++++
 rtl/imuldiv_seq.sv | 131 +++++++++++++
 tb/tb_imuldiv_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_seq_pkg.sv
// Shared multiply/divide operation codes and small arithmetic helpers.
// The instruction decoder and the multiply/divide unit both import this
// package, so the two always agree on the operation encoding.
package imuldiv_seq_pkg;

    localparam int CPU_MULDIV_OP_WIDTH = 4;
    localparam int MULDIV_DATA_W       = 32;

    typedef enum logic [CPU_MULDIV_OP_WIDTH-1:0] {
        CPU_MULDIV_OP_NONE  = 4'd0,
        CPU_MULDIV_OP_MULT  = 4'd1,
        CPU_MULDIV_OP_MULTU = 4'd2,
        CPU_MULDIV_OP_DIV   = 4'd3,
        CPU_MULDIV_OP_DIVU  = 4'd4,
        CPU_MULDIV_OP_MFHI  = 4'd5,
        CPU_MULDIV_OP_MFLO  = 4'd6,
        CPU_MULDIV_OP_MTHI  = 4'd7,
        CPU_MULDIV_OP_MTLO  = 4'd8
    } muldiv_op_e;

    // Magnitude of an operand; unsigned operations pass the value through.
    function automatic logic [MULDIV_DATA_W-1:0] op_magnitude(
        input logic [MULDIV_DATA_W-1:0] val,
        input logic                     is_signed
    );
        return (is_signed && val[MULDIV_DATA_W-1]) ? -val : val;
    endfunction

endpackage

// File: rtl/imuldiv_dp.sv
// Multiply/divide datapath: 64-bit shift register, a single 33-bit
// add/subtract shared by shift-add multiply and restoring divide, and the
// operand magnitude / result negation logic. Sequencing lives in the parent.
module imuldiv_dp
    import imuldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,       // capture operands, start a new op
    input  logic        i_is_div,
    input  logic        i_is_signed,
    input  logic [31:0] i_a,          // multiplicand / dividend
    input  logic [31:0] i_b,          // multiplier / divisor
    input  logic        i_step,       // perform one iteration this cycle
    output logic [31:0] o_hi,         // sign-corrected product high / remainder
    output logic [31:0] o_lo          // sign-corrected product low / quotient
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        neg_q_q, neg_q_d;     // negate product / quotient
    logic        neg_r_q, neg_r_d;     // negate remainder (dividend sign)

    logic [32:0] addsub;
    logic        div_ok;
    logic        a_neg, b_neg, b_zero;

    assign a_neg  = i_is_signed && i_a[31];
    assign b_neg  = i_is_signed && i_b[31];
    assign b_zero = (i_b == 32'd0);

    // Multiply adds the multiplicand into the upper half; divide subtracts the
    // divisor from the left-shifted partial remainder (bit 32 lives in acc[63]).
    assign addsub = is_div_q ? ({1'b0, acc_q[62:31]} - {1'b0, opnd_q})
                             : ({1'b0, acc_q[63:32]} + {1'b0, opnd_q});
    assign div_ok = acc_q[63] | ~addsub[32];

    // Next-state for the shift register and the sign flags captured at load.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block can leave it unassigned (latch inference).
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        if (i_load) begin
            is_div_d = i_is_div;
            if (i_is_div) begin
                acc_d  = {32'd0, op_magnitude(i_a, i_is_signed)};
                opnd_d = op_magnitude(i_b, i_is_signed);
            end else begin
                acc_d  = {32'd0, op_magnitude(i_b, i_is_signed)};
                opnd_d = op_magnitude(i_a, i_is_signed);
            end
            // A zero divisor leaves the all-ones quotient unsigned; the
            // remainder still follows the dividend so HI returns i_a as given.
            neg_q_d = (a_neg ^ b_neg) && !(i_is_div && b_zero);
            neg_r_d = i_is_div && a_neg;
        end else if (i_step) begin
            if (is_div_q) begin
                acc_d = {(div_ok ? addsub[31:0] : acc_q[62:31]), acc_q[30:0], div_ok};
            end else if (acc_q[0]) begin
                acc_d = {addsub, acc_q[31:1]};
            end else begin
                acc_d = {1'b0, acc_q[63:1]};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is cleared on reset as well so that no X ever
        // reaches HI/LO, even though a fresh load overwrites it anyway.
        if (rst) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments only.
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    // Sign correction applied to the finished magnitude result.
    always_comb begin
        o_hi = acc_q[63:32];
        o_lo = acc_q[31:0];
        if (is_div_q) begin
            if (neg_q_q) o_lo = -acc_q[31:0];
            if (neg_r_q) o_hi = -acc_q[63:32];
        end else if (neg_q_q) begin
            {o_hi, o_lo} = -acc_q;
        end
    end

endmodule

// File: rtl/imuldiv_seq.sv
// Sequential integer multiply/divide unit with HI/LO registers.
// MULT/DIV run for ITER cycles plus one sign-fix cycle; MFHI/MFLO/MTHI/MTLO
// complete in one cycle. Only ops presented while busy are stalled.
module imuldiv_seq
    import imuldiv_seq_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CPU_MULDIV_OP_WIDTH-1:0] i_op,
    input  logic [31:0]                    i_rs_val,
    input  logic [31:0]                    i_rt_val,
    input  logic                           i_core_stall,
    input  logic                           i_drop,
    output logic                           o_stall,
    output logic [31:0]                    o_rd_val,
    output logic                           o_rd_valid
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      rd_val_q, rd_val_d;
    logic             rd_valid_q, rd_valid_d;

    logic        op_valid, accept;
    logic        is_mul_op, is_div_op, is_signed_op, is_mf_op;
    logic [31:0] dp_hi, dp_lo;

    assign op_valid     = (i_op != CPU_MULDIV_OP_NONE);
    assign is_mul_op    = (i_op == CPU_MULDIV_OP_MULT) || (i_op == CPU_MULDIV_OP_MULTU);
    assign is_div_op    = (i_op == CPU_MULDIV_OP_DIV)  || (i_op == CPU_MULDIV_OP_DIVU);
    assign is_signed_op = (i_op == CPU_MULDIV_OP_MULT) || (i_op == CPU_MULDIV_OP_DIV);
    assign is_mf_op     = (i_op == CPU_MULDIV_OP_MFHI) || (i_op == CPU_MULDIV_OP_MFLO);

    // NONE never stalls, so unrelated instructions overlap a running op.
    assign o_stall = !rst && op_valid && (state_q != ST_IDLE);
    assign accept  = op_valid && !i_core_stall && !i_drop && !o_stall;

    imuldiv_dp u_dp (
        .clk         (clk),
        .rst         (rst),
        .i_load      (accept && (is_mul_op || is_div_op)),
        .i_is_div    (is_div_op),
        .i_is_signed (is_signed_op),
        .i_a         (i_rs_val),
        .i_b         (i_rt_val),
        .i_step      ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .o_hi        (dp_hi),
        .o_lo        (dp_lo)
    );

    // Sequencer: IDLE -> MUL/DIV for ITER cycles -> FIX for one cycle -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (accept && is_mul_op)      state_q <= ST_MUL;
                    else if (accept && is_div_op) state_q <= ST_DIV;
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FIX;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // HI/LO update and the MFHI/MFLO read port, including stall/drop holding.
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_val_d   = rd_val_q;
        rd_valid_d = rd_valid_q;
        if (state_q == ST_FIX) begin
            hi_d = dp_hi;
            lo_d = dp_lo;
        end else if (accept && (i_op == CPU_MULDIV_OP_MTHI)) begin
            hi_d = i_rs_val;
        end else if (accept && (i_op == CPU_MULDIV_OP_MTLO)) begin
            lo_d = i_rs_val;
        end
        if (accept && is_mf_op) begin
            rd_val_d   = (i_op == CPU_MULDIV_OP_MFHI) ? hi_q : lo_q;
            rd_valid_d = 1'b1;
        end else if (i_drop || !i_core_stall) begin
            rd_valid_d = 1'b0;
        end
    end

    // Architectural HI/LO and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            rd_val_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_val_q   <= rd_val_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_val   = rd_val_q;
    assign o_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_imuldiv_seq.sv
// Self-checking bench for imuldiv_seq: a transaction-level model of HI/LO,
// busy time and the read port, compared every cycle, plus literal checks.
module tb_imuldiv_seq;
    import imuldiv_seq_pkg::*;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        cs, drop;
    logic        stall;
    logic [31:0] rd_val;
    logic        rd_valid;

    always #5 clk = ~clk;

    imuldiv_seq #(.ITER(ITER)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_op         (op),
        .i_rs_val     (rs),
        .i_rt_val     (rt),
        .i_core_stall (cs),
        .i_drop       (drop),
        .o_stall      (stall),
        .o_rd_val     (rd_val),
        .o_rd_valid   (rd_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mul_ref(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (o == CPU_MULDIV_OP_MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {HI, LO} = {remainder, quotient}.
    function automatic logic [63:0] div_ref(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == CPU_MULDIV_OP_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0, m_rd_val = '0;
    logic        m_rd_valid = 1'b0;
    int          m_busy = 0;      // edges left until the running op commits
    bit          cmp_en = 1'b0;

    function automatic bit m_accept();
        return (op != CPU_MULDIV_OP_NONE) && !cs && !drop && !rst && (m_busy == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= '0; m_lo <= '0; m_rd_val <= '0; m_rd_valid <= 1'b0; m_busy <= 0;
        end else begin
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_hi <= m_pend_hi;
                    m_lo <= m_pend_lo;
                end
            end
            if (m_accept()) begin
                case (op)
                    CPU_MULDIV_OP_MULT, CPU_MULDIV_OP_MULTU: begin
                        {m_pend_hi, m_pend_lo} <= mul_ref(op, rs, rt);
                        m_busy <= ITER + 1;
                    end
                    CPU_MULDIV_OP_DIV, CPU_MULDIV_OP_DIVU: begin
                        {m_pend_hi, m_pend_lo} <= div_ref(op, rs, rt);
                        m_busy <= ITER + 1;
                    end
                    CPU_MULDIV_OP_MTHI: m_hi <= rs;
                    CPU_MULDIV_OP_MTLO: m_lo <= rs;
                    CPU_MULDIV_OP_MFHI: m_rd_val <= m_hi;
                    CPU_MULDIV_OP_MFLO: m_rd_val <= m_lo;
                    default: ;
                endcase
                m_rd_valid <= (op == CPU_MULDIV_OP_MFHI) || (op == CPU_MULDIV_OP_MFLO);
            end else if (drop || !cs) begin
                m_rd_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", stall, !rst && (op != CPU_MULDIV_OP_NONE) && (m_busy != 0));
            check("rd_valid", rd_valid, m_rd_valid);
            if (m_rd_valid) check("rd_val", rd_val, m_rd_val);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        op = o; rs = a; rt = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = m_accept();
            @(posedge clk); #1;
        end
        // Operands change right after acceptance; the result must not care.
        op = CPU_MULDIV_OP_NONE; rs = $urandom; rt = $urandom;
        check("issue_accepted", done, 1'b1);
    endtask

    task automatic read_reg(input logic [3:0] o, input logic [31:0] exp, input string name);
        issue(o, $urandom, $urandom);
        check({name, "_valid"}, rd_valid, 1'b1);
        check(name, rd_val, exp);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; op = CPU_MULDIV_OP_MULT; rs = 32'd5; rt = 32'd6; cs = 1'b0; drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_in_reset", stall, 1'b0);
        check("rd_valid_reset", rd_valid, 1'b0);
        check("rd_val_reset", rd_val, 32'd0);
        rst = 1'b0; op = CPU_MULDIV_OP_NONE;
        cmp_en = 1'b1;
        read_reg(CPU_MULDIV_OP_MFHI, 32'd0, "hi_reset");
        read_reg(CPU_MULDIV_OP_MFLO, 32'd0, "lo_reset");

        // -2 * 3, with the commit edge pinned exactly.
        issue(CPU_MULDIV_OP_MTLO, 32'h55AA_55AA, 32'd0);
        issue(CPU_MULDIV_OP_MULT, 32'hFFFF_FFFE, 32'd3);
        repeat (ITER) @(posedge clk);
        #1 check("lo_before_commit", dut.lo_q, 32'h55AA_55AA);
        @(posedge clk);
        #1 check("lo_at_commit", dut.lo_q, 32'hFFFF_FFFA);
        read_reg(CPU_MULDIV_OP_MFLO, 32'hFFFF_FFFA, "mult_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'hFFFF_FFFF, "mult_hi");

        issue(CPU_MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_reg(CPU_MULDIV_OP_MFHI, 32'hFFFF_FFFE, "multu_hi");
        read_reg(CPU_MULDIV_OP_MFLO, 32'h0000_0001, "multu_lo");

        issue(CPU_MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        read_reg(CPU_MULDIV_OP_MFLO, 32'hFFFF_FFFD, "div_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'hFFFF_FFFF, "div_hi");
        issue(CPU_MULDIV_OP_DIVU, 32'd100, 32'd0);
        read_reg(CPU_MULDIV_OP_MFLO, 32'hFFFF_FFFF, "divu0_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'd100, "divu0_hi");
        issue(CPU_MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd0);
        read_reg(CPU_MULDIV_OP_MFLO, 32'hFFFF_FFFF, "div0_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'hFFFF_FFF9, "div0_hi");
        issue(CPU_MULDIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_reg(CPU_MULDIV_OP_MFLO, 32'h8000_0000, "div_ovf_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'h0000_0000, "div_ovf_hi");
        issue(CPU_MULDIV_OP_DIVU, 32'hFFFF_FFFF, 32'd7);
        read_reg(CPU_MULDIV_OP_MFLO, 32'h2492_4924, "divu_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'd3, "divu_hi");

        // MFHI presented while 7x9 runs: stalled, NONE is not.
        issue(CPU_MULDIV_OP_MULT, 32'd7, 32'd9);
        repeat (4) @(posedge clk);
        #1 check("stall_none_op", stall, 1'b0);
        op = CPU_MULDIV_OP_MFHI;
        #1 check("stall_mf_busy", stall, 1'b1);
        read_reg(CPU_MULDIV_OP_MFHI, 32'd0, "mul79_hi");
        read_reg(CPU_MULDIV_OP_MFLO, 32'd63, "mul79_lo");

        // Read port holds under core stall, drops after.
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("rd_hold_valid", rd_valid, 1'b1);
        check("rd_hold_val", rd_val, 32'd63);
        cs = 1'b0;
        @(posedge clk);
        #1 check("rd_release", rd_valid, 1'b0);

        // MTLO blocked by core stall for 3 cycles.
        cs = 1'b1; op = CPU_MULDIV_OP_MTLO; rs = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 check("mtlo_stalled", dut.lo_q, 32'd63);
        cs = 1'b0;
        @(posedge clk);
        #1 op = CPU_MULDIV_OP_NONE;
        read_reg(CPU_MULDIV_OP_MFLO, 32'h1234_5678, "mtlo_lo");

        // Drop during a multiply does not abort it.
        issue(CPU_MULDIV_OP_MULT, 32'd1000, 32'hFFFF_FFFD);
        drop = 1'b1; op = CPU_MULDIV_OP_MFHI;
        repeat (5) @(posedge clk);
        #1 drop = 1'b0; op = CPU_MULDIV_OP_NONE;
        read_reg(CPU_MULDIV_OP_MFLO, 32'hFFFF_F448, "drop_mul_lo");
        read_reg(CPU_MULDIV_OP_MFHI, 32'hFFFF_FFFF, "drop_mul_hi");

        // Reset in the middle of a divide.
        issue(CPU_MULDIV_OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1; op = CPU_MULDIV_OP_MFHI;
        @(posedge clk);
        #1 rst = 1'b0;
        check("stall_after_rst", stall, 1'b0);
        check("rd_valid_after_rst", rd_valid, 1'b0);
        read_reg(CPU_MULDIV_OP_MFHI, 32'd0, "hi_after_rst");
        read_reg(CPU_MULDIV_OP_MFLO, 32'd0, "lo_after_rst");
        op = CPU_MULDIV_OP_MFLO; drop = 1'b1;
        @(posedge clk);
        #1 check("drop_mf_valid", rd_valid, 1'b0);
        drop = 1'b0; op = CPU_MULDIV_OP_NONE;

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            op   = ($urandom_range(0, 2) == 0) ? CPU_MULDIV_OP_NONE : 4'($urandom_range(1, 8));
            rs   = rand_operand();
            rt   = rand_operand();
            cs   = ($urandom_range(0, 9) == 0);
            drop = ($urandom_range(0, 14) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; cs = 1'b0; drop = 1'b0; op = CPU_MULDIV_OP_NONE;
        repeat (ITER + 4) @(posedge clk);
        #1;
        read_reg(CPU_MULDIV_OP_MFHI, m_hi, "final_hi");
        read_reg(CPU_MULDIV_OP_MFLO, m_lo, "final_lo");

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
